// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: an input capture register followed by one registered
// shift level per bit of the shift amount, with a single stall-all handshake.
module barrel_shift_pipe #(
    parameter int WIDTH  = 64,
    parameter int SAMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SAMT_W-1:0] in_samt,
    input  logic [2:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_ovf,
    output logic              out_err
);

    typedef enum logic [2:0] {
        MODE_LSL = 3'b000,
        MODE_LSR = 3'b001,
        MODE_ASR = 3'b010,
        MODE_ASL = 3'b011,
        MODE_ROL = 3'b100,
        MODE_ROR = 3'b101
    } mode_e;

    // Index 0 is the operand capture register; index s (1..SAMT_W) holds the
    // result after shifting by bit SAMT_W-s of the amount.
    logic              vld_q  [0:SAMT_W];
    logic [WIDTH-1:0]  data_q [0:SAMT_W];
    logic              ovf_q  [0:SAMT_W];
    logic              err_q  [0:SAMT_W];
    logic [SAMT_W-1:0] samt_q [0:SAMT_W-1];
    logic [2:0]        mode_q [0:SAMT_W-1];
    logic              sign_q [0:SAMT_W-1];
    logic [WIDTH:0]    step_d [1:SAMT_W];
    logic              adv;

    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input logic             sign,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        logic [WIDTH-2:0] ones;
        logic [WIDTH-2:0] hi_mask;
        logic [WIDTH-2:0] low;
        logic             ov;
        r       = d;
        ov      = 1'b0;
        fill    = ~({WIDTH{1'b1}} >> amt);
        ones    = '1;
        hi_mask = ~(ones >> amt);
        low     = d[WIDTH-2:0] << amt;
        case (mode)
            MODE_LSL: r = d << amt;
            MODE_LSR: r = d >> amt;
            MODE_ASR: r = (d >> amt) | (fill & {WIDTH{sign}});
            MODE_ASL: begin
                // Sign bit is pinned; any magnitude bit pushed past it that
                // disagrees with the sign means the value no longer fits.
                r  = {sign, low};
                ov = |((d[WIDTH-2:0] ^ {(WIDTH-1){sign}}) & hi_mask);
            end
            MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
            MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
            default:  r = d;
        endcase
        return {ov, r};
    endfunction

    assign adv       = !vld_q[SAMT_W] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[SAMT_W];
    assign out_data  = data_q[SAMT_W];
    assign out_ovf   = ovf_q[SAMT_W];
    assign out_err   = err_q[SAMT_W];

    always_comb begin
        int amt;
        for (int s = 1; s <= SAMT_W; s++) begin
            amt       = 1 << (SAMT_W - s);
            step_d[s] = {1'b0, data_q[s-1]};
            if (samt_q[s-1][SAMT_W-1]) begin
                step_d[s] = shift_step(data_q[s-1], mode_q[s-1], sign_q[s-1], amt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= SAMT_W; s++) begin
                vld_q[s]  <= 1'b0;
                data_q[s] <= '0;
                ovf_q[s]  <= 1'b0;
                err_q[s]  <= 1'b0;
            end
            for (int s = 0; s < SAMT_W; s++) begin
                samt_q[s] <= '0;
                mode_q[s] <= '0;
                sign_q[s] <= 1'b0;
            end
        end else if (adv) begin
            // Capture stage: operand fields are sampled only on accept.
            vld_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
                samt_q[0] <= in_samt;
                mode_q[0] <= in_mode;
                sign_q[0] <= in_data[WIDTH-1];
                ovf_q[0]  <= 1'b0;
                err_q[0]  <= in_mode[2] & in_mode[1];
            end
            // Shift stages: the amount is consumed MSB-first by shifting it left.
            for (int s = 1; s <= SAMT_W; s++) begin
                vld_q[s]  <= vld_q[s-1];
                data_q[s] <= step_d[s][WIDTH-1:0];
                ovf_q[s]  <= ovf_q[s-1] | step_d[s][WIDTH];
                err_q[s]  <= err_q[s-1];
            end
            for (int s = 1; s < SAMT_W; s++) begin
                samt_q[s] <= samt_q[s-1] << 1;
                mode_q[s] <= mode_q[s-1];
                sign_q[s] <= sign_q[s-1];
            end
        end
    end

endmodule
